// File: rtl/logip_ctrl_pkg.sv
// Shared constants for the logIP capture/readout controller: count width,
// command field offsets and FSM state encoding.
package logip_ctrl_pkg;

    localparam int CNT_W     = 16;
    localparam int READ_LSB  = 0;
    localparam int DELAY_LSB = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_DELAY   = 2'd1;
    localparam state_t ST_TX_REQ  = 2'd2;
    localparam state_t ST_TX_WAIT = 2'd3;

endpackage

// File: rtl/logip_dcnt.sv
// Loadable down-counter used for both the post-trigger delay and the
// readout word count.
module logip_dcnt #(
    parameter int W = 18
) (
    input  logic         clk_i,
    input  logic         rst_in,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] cnt_r;

    // Load wins over decrement; decrement never wraps below zero
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_r <= ZERO;
        end else if (load_i) begin
            cnt_r <= load_val_i;
        end else if (dec_i && (cnt_r != ZERO)) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/logip_ctrl.sv
// logIP capture/readout controller: waits out the post-trigger delay, then
// paces the memory readout through the UART transmitter one word per busy period.
module logip_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_in,
    input  logic               set_cnt_i,
    input  logic [2*CNT_W-1:0] cmd_i,
    input  logic               run_i,
    input  logic               stb_i,
    input  logic               tx_rdy_i,
    output logic               tx_stb_o,
    output logic               tx_sel_o
);

    import logip_ctrl_pkg::*;

    // The read counter needs one extra bit: 4*(0xFFFF+1) is 2^18.
    localparam int DCNT_W = CNT_W + 2;
    localparam int RCNT_W = CNT_W + 3;
    localparam logic [DCNT_W-1:0] DCNT_ONE  = {{(DCNT_W-1){1'b0}}, 1'b1};
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
    localparam logic [RCNT_W-1:0] RCNT_ZERO = {RCNT_W{1'b0}};
    localparam logic [RCNT_W-1:0] RCNT_FOUR = {{(RCNT_W-3){1'b0}}, 3'b100};

    logic [CNT_W-1:0]  read_cnt_r;
    logic [CNT_W-1:0]  delay_cnt_r;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              tx_stb_r;
    logic              tx_sel_r;
    logic              stb_nxt_s;
    logic              arm_s;
    logic              ddec_s;
    logic              rdec_s;
    logic [DCNT_W-1:0] dload_val_s;
    logic [RCNT_W-1:0] rload_val_s;
    logic [DCNT_W-1:0] dcnt_s;
    logic [RCNT_W-1:0] rcnt_s;

    assign arm_s       = (state_r == ST_IDLE) && run_i;
    assign ddec_s      = (state_r == ST_DELAY) && stb_i;
    assign rdec_s      = (state_r == ST_TX_REQ) && tx_rdy_i;
    assign dload_val_s = {delay_cnt_r, 2'b00};
    assign rload_val_s = {1'b0, read_cnt_r, 2'b00} + RCNT_FOUR;

    logip_dcnt #(.W(DCNT_W)) u_dcnt (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .load_i     (arm_s),
        .load_val_i (dload_val_s),
        .dec_i      (ddec_s),
        .cnt_o      (dcnt_s)
    );

    logip_dcnt #(.W(RCNT_W)) u_rcnt (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .load_i     (arm_s),
        .load_val_i (rload_val_s),
        .dec_i      (rdec_s),
        .cnt_o      (rcnt_s)
    );

    // Count registers; a load mid-capture only takes effect at the next arm
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            read_cnt_r  <= {CNT_W{1'b0}};
            delay_cnt_r <= {CNT_W{1'b0}};
        end else if (set_cnt_i) begin
            read_cnt_r  <= cmd_i[READ_LSB +: CNT_W];
            delay_cnt_r <= cmd_i[DELAY_LSB +: CNT_W];
        end else begin
            read_cnt_r  <= read_cnt_r;
            delay_cnt_r <= delay_cnt_r;
        end
    end

    // Next-state and next-strobe decode
    always_comb begin
        state_nxt_s = state_r;
        stb_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run_i) begin
                    state_nxt_s = (dload_val_s != DCNT_ZERO) ? ST_DELAY : ST_TX_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (stb_i && (dcnt_s == DCNT_ONE)) begin
                    state_nxt_s = ST_TX_REQ;
                end else begin
                    state_nxt_s = ST_DELAY;
                end
            end
            ST_TX_REQ: begin
                if (tx_rdy_i) begin
                    state_nxt_s = ST_TX_WAIT;
                    stb_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_TX_REQ;
                end
            end
            ST_TX_WAIT: begin
                // Only a drop of tx_rdy_i proves the transmitter took the word
                if (!tx_rdy_i) begin
                    state_nxt_s = (rcnt_s == RCNT_ZERO) ? ST_IDLE : ST_TX_REQ;
                end else begin
                    state_nxt_s = ST_TX_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered Moore outputs
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_r  <= ST_IDLE;
            tx_stb_r <= 1'b0;
            tx_sel_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            tx_stb_r <= stb_nxt_s;
            tx_sel_r <= (state_nxt_s == ST_TX_REQ) || (state_nxt_s == ST_TX_WAIT);
        end
    end

    assign tx_stb_o = tx_stb_r;
    assign tx_sel_o = tx_sel_r;

endmodule

// File: tb/tb_logip_ctrl.sv
// Scoreboard bench for logip_ctrl: the arm task queues one expected word per
// readout strobe from a count-level model; a monitor pops and checks each strobe.
module tb_logip_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_in;
    logic        set_cnt_i;
    logic [31:0] cmd_i;
    logic        run_i;
    logic        stb_i;
    logic        tx_rdy_i;
    logic        tx_stb_o;
    logic        tx_sel_o;

    logip_ctrl dut (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .set_cnt_i (set_cnt_i),
        .cmd_i     (cmd_i),
        .run_i     (run_i),
        .stb_i     (stb_i),
        .tx_rdy_i  (tx_rdy_i),
        .tx_stb_o  (tx_stb_o),
        .tx_sel_o  (tx_sel_o)
    );

    typedef struct {
        int idx;
        int delay_req;
        int exp_cyc;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int samples_drv = 0;
    int samples_cnt = 0;
    int samples_d1 = 0;
    int strobes_total = 0;
    int m_read = 0;
    int m_delay = 0;
    int lag = 0;
    int busy = 3;
    int lag_cnt = 0;
    int busy_cnt = 0;
    bit stuck = 1'b0;
    bit dropped = 1'b0;
    bit prev_rdy = 1'b0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Transmitter: stays ready for 'lag' cycles after a strobe, then busy for 'busy'.
    initial begin
        tx_rdy_i = 1'b1;
        forever begin
            tick();
            if (tx_stb_o === 1'b1) begin
                lag_cnt  = lag;
                busy_cnt = busy;
            end
            if (stuck) begin
                tx_rdy_i = 1'b0;
            end else if (lag_cnt > 0) begin
                tx_rdy_i = 1'b1;
                lag_cnt--;
            end else if (busy_cnt > 0) begin
                tx_rdy_i = 1'b0;
                busy_cnt--;
            end else begin
                tx_rdy_i = 1'b1;
            end
        end
    end

    // Monitor: every strobe must match a queued word and obey delay/handshake rules.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_in === 1'b1) begin
                if (tx_stb_o === 1'b1) begin
                    strobes_total++;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_strobe", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sel_at_strobe", int'(tx_sel_o), 1);
                        chk("delay_met", int'(samples_d1 >= e.delay_req), 1);
                        chk("rdy_at_issue", int'(prev_rdy), 1);
                        if (e.idx > 0) chk("handshake_drop", int'(dropped), 1);
                        if (e.exp_cyc >= 0) chk("first_latency", cyc, e.exp_cyc);
                    end
                    dropped = 1'b0;
                end
                if (tx_rdy_i === 1'b0) dropped = 1'b1;
            end
            prev_rdy   = tx_rdy_i;
            samples_d1 = samples_cnt;
            if (stb_i === 1'b1) samples_cnt++;
        end
    end

    task automatic set_cnt(input logic [31:0] v);
        set_cnt_i = 1'b1;
        cmd_i     = v;
        tick();
        set_cnt_i = 1'b0;
        m_read    = int'(v[15:0]);
        m_delay   = int'(v[31:16]);
    endtask

    task automatic arm(input bit with_set, input logic [31:0] v, output int words, output int del);
        exp_t e;
        words = 4 * (m_read + 1);
        del   = 4 * m_delay;
        for (int i = 0; i < words; i++) begin
            e.idx       = i;
            e.delay_req = samples_drv + del;
            e.exp_cyc   = (i == 0 && del == 0 && !stuck && tx_rdy_i === 1'b1) ? cyc + 2 : -1;
            sb_q.push_back(e);
        end
        run_i = 1'b1;
        if (with_set) begin
            set_cnt_i = 1'b1;
            cmd_i     = v;
        end
        tick();
        run_i     = 1'b0;
        set_cnt_i = 1'b0;
        if (with_set) begin
            m_read  = int'(v[15:0]);
            m_delay = int'(v[31:16]);
        end
    endtask

    task automatic send_samples(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            stb_i = 1'b1;
            samples_drv++;
            tick();
            stb_i = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int words, input int start);
        int budget;
        budget = words * (lag + busy + 8) + 200;
        while (sb_q.size() > 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk({name, "_timeout"}, sb_q.size(), 0);
        sb_q.delete();
        repeat (lag + busy + 4) tick();
        chk({name, "_words"}, strobes_total - start, words);
        chk({name, "_sel_idle"}, int'(tx_sel_o), 0);
    endtask

    task automatic run_burst(input bit with_set, input logic [31:0] v, input string name);
        int start;
        int words;
        int del;
        start = strobes_total;
        arm(with_set, v, words, del);
        send_samples(del);
        wait_done(name, words, start);
    endtask

    initial begin
        int start;
        int words;
        int del;
        bit found;
        logic [31:0] v;

        rst_in    = 1'b0;
        set_cnt_i = 1'b0;
        cmd_i     = 32'h0000_0000;
        run_i     = 1'b0;
        stb_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_stb", int'(tx_stb_o), 0);
        chk("rst_sel", int'(tx_sel_o), 0);
        rst_in = 1'b1;
        tick();
        tick();

        lag = 0; busy = 3;
        run_burst(1'b0, 32'h0, "t1_reset_counts");

        set_cnt(32'h0002_0001);
        run_burst(1'b0, 32'h0, "t2_delay8_read8");

        set_cnt(32'h0000_0003);
        stuck = 1'b1;
        tick();
        tick();
        start = strobes_total;
        arm(1'b0, 32'h0, words, del);
        repeat (10) tick();
        chk("t3_sel_stuck", int'(tx_sel_o), 1);
        chk("t3_no_strobe", strobes_total - start, 0);
        stuck = 1'b0;
        wait_done("t3_release", words, start);

        set_cnt(32'h0000_0000);
        lag = 5; busy = 2;
        run_burst(1'b0, 32'h0, "t4_handshake");

        set_cnt(32'h0001_0000);
        lag = 0; busy = 2;
        start = strobes_total;
        arm(1'b0, 32'h0, words, del);
        send_samples(2);
        set_cnt(32'h0000_0000);
        send_samples(del - 2);
        wait_done("t5_mid_load", words, start);
        run_burst(1'b0, 32'h0, "t5_next_arm");

        run_burst(1'b1, 32'h0001_0001, "t6_same_cycle");
        run_burst(1'b0, 32'h0, "t6_new_counts");

        set_cnt(32'h0000_0001);
        lag = 20; busy = 2;
        arm(1'b0, 32'h0, words, del);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (tx_stb_o === 1'b1) found = 1'b1;
            else tick();
        end
        chk("t7_strobe_seen", int'(found), 1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("t7_async_stb", int'(tx_stb_o), 0);
        chk("t7_async_sel", int'(tx_sel_o), 0);
        sb_q.delete();
        m_read  = 0;
        m_delay = 0;
        repeat (30) tick();
        rst_in = 1'b1;
        tick();
        lag = 0; busy = 3;
        run_burst(1'b0, 32'h0, "t7_after_reset");

        for (int k = 0; k < 8; k++) begin
            lag  = $urandom_range(0, 3);
            busy = $urandom_range(1, 4);
            v    = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 0) begin
                set_cnt(v);
                run_burst(1'b0, 32'h0, "rnd");
            end else begin
                run_burst(1'b1, v, "rnd_same_cycle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
